// File: rtl/cpu_pkg.sv
// Shared definitions for the PC/branch path: next-PC select encoding,
// fetch step and reset vector.
package cpu_pkg;

    typedef enum logic [1:0] {
        SEL_SEQ = 2'd0,
        SEL_BR  = 2'd1,
        SEL_J   = 2'd2,
        SEL_JR  = 2'd3
    } pc_sel_t;

    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Word offset to byte offset: sign-extend imm16 and scale by 4.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/branch_pc_unit_if.sv
// Control, flag and address signals between decoder/ALU, the PC unit
// and the instruction-memory address port.
interface branch_pc_unit_if #(
    parameter int CNT_W = 16
);
    logic              zero;
    logic              branch_eq;
    logic              branch_ne;
    logic              jump;
    logic              jump_reg;
    logic [15:0]       imm16;
    logic [25:0]       target26;
    logic [31:0]       rs_data;
    logic              stall;
    logic [31:0]       pc;
    logic [31:0]       pc_plus4;
    logic              taken;
    logic              misalign;
    logic [CNT_W-1:0]  taken_count;

    modport master (
        output zero, branch_eq, branch_ne, jump, jump_reg,
               imm16, target26, rs_data, stall,
        input  pc, pc_plus4, taken, misalign, taken_count
    );

    modport slave (
        input  zero, branch_eq, branch_ne, jump, jump_reg,
               imm16, target26, rs_data, stall,
        output pc, pc_plus4, taken, misalign, taken_count
    );
endinterface

// File: rtl/next_pc_sel.sv
// Combinational next-PC selection: target adders and the
// jr > j > branch > sequential priority mux.
module next_pc_sel
    import cpu_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        zero,
    input  logic        branch_eq,
    input  logic        branch_ne,
    input  logic        jump,
    input  logic        jump_reg,
    input  logic [15:0] imm16,
    input  logic [25:0] target26,
    input  logic [29:0] rs_word,
    output logic [31:0] pc_plus4,
    output logic [31:0] next_pc,
    output pc_sel_t     sel
);
    logic        cond;
    logic [31:0] br_target;
    logic [31:0] j_target;
    logic [31:0] jr_target;

    assign pc_plus4  = pc + PC_STEP;
    assign cond      = (branch_eq & zero) | (branch_ne & ~zero);
    assign br_target = pc_plus4 + branch_offset(imm16);
    assign j_target  = {pc_plus4[31:28], target26, 2'b00};
    assign jr_target = {rs_word, 2'b00};

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        sel = SEL_SEQ;
        if (jump_reg)  sel = SEL_JR;
        else if (jump) sel = SEL_J;
        else if (cond) sel = SEL_BR;
    end

    always_comb begin
        next_pc = pc_plus4;
        case (sel)
            SEL_JR:  next_pc = jr_target;
            SEL_J:   next_pc = j_target;
            SEL_BR:  next_pc = br_target;
            default: next_pc = pc_plus4;
        endcase
    end
endmodule

// File: rtl/branch_pc_unit.sv
// Architectural PC register, redirect/misalign flags and saturating
// taken-branch counter around the next-PC selector.
module branch_pc_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          CNT_W    = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    branch_pc_unit_if.slave         bus
);
    logic [31:0]      pc_q;
    logic [31:0]      pc_plus4;
    logic [31:0]      next_pc;
    pc_sel_t          sel;
    logic             redirect;
    logic             jr_misalign;
    logic             taken_q;
    logic             misalign_q;
    logic [CNT_W-1:0] count_q;

    next_pc_sel u_sel (
        .pc        (pc_q),
        .zero      (bus.zero),
        .branch_eq (bus.branch_eq),
        .branch_ne (bus.branch_ne),
        .jump      (bus.jump),
        .jump_reg  (bus.jump_reg),
        .imm16     (bus.imm16),
        .target26  (bus.target26),
        .rs_word   (bus.rs_data[31:2]),
        .pc_plus4  (pc_plus4),
        .next_pc   (next_pc),
        .sel       (sel)
    );

    assign redirect    = (sel != SEL_SEQ);
    assign jr_misalign = (sel == SEL_JR) && (bus.rs_data[1:0] != 2'b00);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            taken_q    <= 1'b0;
            misalign_q <= 1'b0;
            count_q    <= '0;
        end else if (bus.stall) begin
            taken_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= next_pc;
            taken_q    <= redirect;
            misalign_q <= jr_misalign;
            if (redirect && (count_q != '1))
                count_q <= count_q + 1'b1;
        end
    end

    assign bus.pc          = pc_q;
    assign bus.pc_plus4    = pc_plus4;
    assign bus.taken       = taken_q;
    assign bus.misalign    = misalign_q;
    assign bus.taken_count = count_q;
endmodule

// File: doc/branch_pc_unit.md
# branch_pc_unit

Program-counter and branch-resolution block for the single-cycle CPU datapath. It is the consumer of the ALU zero flag: it combines the flag with the decoded branch and jump controls and selects the next instruction address. It also holds the architectural PC register and a saturating taken-branch counter for lab measurements. It sits between the ALU's zero output, the control decoder and the instruction memory address port.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- CNT_W, 16: width of the taken-branch counter.

- clk  input  1  rising-edge clock for all state.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- zero  input  1  ALU zero flag for the current instruction.
- branch_eq  input  1  decoded beq.
- branch_ne  input  1  decoded bne.
- jump  input  1  decoded j/jal.
- jump_reg  input  1  decoded jr.
- imm16  input  16  branch offset in words, signed.
- target26  input  26  jump word target.
- rs_data  input  32  register value for jr.
- stall  input  1  hold PC and counter this cycle.
- pc  output  32  current instruction address, registered.
- pc_plus4  output  32  pc + 4, combinational from pc.
- taken  output  1  registered; 1 if the last PC update was a redirect.
- misalign  output  1  registered one-cycle pulse; jr target had nonzero bits [1:0].
- taken_count  output  CNT_W  saturating count of redirects.

## Operation
- pc_plus4 = pc + 4, modulo 2^32.
- Branch condition: cond = (branch_eq & zero) | (branch_ne & ~zero). If both branch_eq and branch_ne are asserted, the condition is always true.
- Branch target: pc_plus4 + (sign_extend(imm16) << 2), modulo 2^32. Wrap-around is legal and is not flagged.
- Jump target: {pc_plus4[31:28], target26, 2'b00}.
- jr target: {rs_data[31:2], 2'b00}.
- Next-PC priority, highest first:
  1. stall: hold.
  2. jump_reg: jr target.
  3. jump: jump target.
  4. cond: branch target.
  5. Otherwise: pc_plus4.
- Redirect: a non-stalled update that selects jr, jump or branch target.
- Counter behaviour:
  - taken_count increments by 1 on each redirect.
  - It saturates at all-ones and stays there.
- misalign is set to 1 for one cycle when jr is selected with rs_data[1:0] != 0. Otherwise it is 0.
- Behaviour during a stalled cycle:
  - pc and taken_count hold.
  - taken and misalign are cleared to 0.
  - All control inputs are ignored.

## Timing
- Reset values, applied asynchronously on assertion: pc = RESET_PC, taken = 0, misalign = 0, taken_count = 0.
- State updates only on the rising edge of clk while reset is low.
- Reset asserted mid-operation overrides any pending redirect. The first edge after deassertion fetches from RESET_PC + 4 or from a redirect target.
- Next-PC latency: zero cycles from inputs to next-PC (combinational). The new pc is visible one cycle after the edge.
- taken and misalign describe the update made on the most recent edge.
- No handshake: inputs are sampled every non-stalled edge.

## Structure
- Shared package `cpu_pkg`:
  - next-PC select encoding (SEL_SEQ, SEL_BR, SEL_J, SEL_JR);
  - constant PC_STEP = 4;
  - reset-vector default.
- One natural sub-module, `next_pc_sel`: the combinational priority mux and the target adders.
- The top level holds the pc, flag and counter registers.

## Test plan
- Reset and sequential fetch: reset high, then low; no controls for 3 cycles -> pc goes 0, 4, 8, 12; taken = 0; taken_count = 0.
- Branch on zero flag:
  - pc = 0x100, branch_eq = 1, zero = 1, imm16 = 0xFFFE -> pc = 0x0FC, taken = 1, count = 1.
  - Same with zero = 0 -> pc = 0x104, taken = 0.
- Priority and jump:
  - pc = 0x1000_0000, jump = 1, jump_reg = 1, rs_data = 0x0000_2002 -> pc = 0x0000_2000, misalign = 1 for one cycle.
  - jump only with target26 = 0x10 -> pc = 0x1000_0040.
- Stall: stall = 1 together with branch_eq = 1 and zero = 1 for 2 cycles -> pc unchanged, count unchanged, taken = 0.
- Wrap and saturation:
  - pc = 0xFFFF_FFFC, no control -> pc = 0x0000_0000.
  - With CNT_W = 4, 20 consecutive taken branches -> taken_count stops at 15.
- Reset mid-operation: assert reset between edges during a jump -> pc = RESET_PC and count = 0 immediately, without waiting for a clock edge.
